// File: rtl/alu_sequencer.sv
// Microcoded fetch/decode/execute controller for the 8-bit accumulator datapath.
// The step counter and IR opcode select the control strobes; the ALU carry is latched for JC.
module alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [OPW-1:0] ir_opcode,
  input  logic           carry_in,
  output logic           pc_out,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           mar_load,
  output logic           ram_out,
  output logic           ram_write,
  output logic           ir_load,
  output logic           ir_out,
  output logic           alu_enable,
  output logic           rega_enable,
  output logic           rega_write_enable,
  output logic           regb_write_enable,
  output logic           sub_enable,
  output logic           out_load,
  output logic           carry_flag,
  output logic           halted,
  output logic [2:0]     step
);

  localparam int OPERAND_W = WIDTH - OPW;

  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_STA = OPW'(4);
  localparam logic [OPW-1:0] OP_LDI = OPW'(5);
  localparam logic [OPW-1:0] OP_JMP = OPW'(6);
  localparam logic [OPW-1:0] OP_JC  = OPW'(7);
  localparam logic [OPW-1:0] OP_OUT = OPW'(14);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t     state_reg;
  logic [2:0] step_reg;
  logic       carry_flag_reg;
  logic [2:0] last_step;
  logic       active;

  // Final micro-step of each instruction; unknown opcodes finish with the fetch.
  always_comb begin
    last_step = 3'd1;
    case (ir_opcode)
      OP_LDA, OP_STA:                         last_step = 3'd3;
      OP_ADD, OP_SUB:                         last_step = 3'd4;
      OP_LDI, OP_JMP, OP_JC, OP_OUT, OP_HLT:  last_step = 3'd2;
      default:                                last_step = 3'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_RUN;
      step_reg       <= 3'd0;
      carry_flag_reg <= 1'b0;
    end else if (run && state_reg == S_RUN) begin
      if ((ir_opcode == OP_ADD || ir_opcode == OP_SUB) && step_reg == 3'd4)
        carry_flag_reg <= carry_in;
      if (ir_opcode == OP_HLT && step_reg == 3'd2) begin
        state_reg <= S_HALT;
        step_reg  <= 3'd0;
      end else if (step_reg == last_step) begin
        step_reg <= 3'd0;
      end else begin
        step_reg <= step_reg + 3'd1;
      end
    end
  end

  assign active = rst_n && run && (state_reg == S_RUN);

  always_comb begin
    pc_out = 1'b0; pc_inc = 1'b0; pc_load = 1'b0; mar_load = 1'b0;
    ram_out = 1'b0; ram_write = 1'b0; ir_load = 1'b0; ir_out = 1'b0;
    alu_enable = 1'b0; rega_enable = 1'b0; rega_write_enable = 1'b0;
    regb_write_enable = 1'b0; sub_enable = 1'b0; out_load = 1'b0;
    if (active) begin
      case (step_reg)
        3'd0: begin pc_out = 1'b1; mar_load = 1'b1; end
        3'd1: begin ram_out = 1'b1; ir_load = 1'b1; pc_inc = 1'b1; end
        3'd2: begin
          case (ir_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ir_out = 1'b1; mar_load = 1'b1; end
            OP_LDI: begin ir_out = 1'b1; rega_write_enable = 1'b1; end
            OP_JMP: begin ir_out = 1'b1; pc_load = 1'b1; end
            OP_JC:  begin ir_out = carry_flag_reg; pc_load = carry_flag_reg; end
            OP_OUT: begin rega_enable = 1'b1; out_load = 1'b1; end
            default: ;
          endcase
        end
        3'd3: begin
          case (ir_opcode)
            OP_LDA:         begin ram_out = 1'b1; rega_write_enable = 1'b1; end
            OP_ADD, OP_SUB: begin ram_out = 1'b1; regb_write_enable = 1'b1; end
            OP_STA:         begin rega_enable = 1'b1; ram_write = 1'b1; end
            default: ;
          endcase
        end
        3'd4: begin
          if (ir_opcode == OP_ADD || ir_opcode == OP_SUB) begin
            alu_enable        = 1'b1;
            rega_write_enable = 1'b1;
            sub_enable        = (ir_opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign carry_flag = carry_flag_reg;
  assign halted     = (state_reg == S_HALT);
  assign step       = step_reg;

  a_operand_field: assert property (@(posedge clk) OPERAND_W > 0);
  a_one_driver: assert property (@(posedge clk)
    $onehot0({pc_out, ram_out, ir_out, alu_enable, rega_enable}));
  a_one_reg_writer: assert property (@(posedge clk) !(rega_write_enable && regb_write_enable));
  a_sub_with_alu: assert property (@(posedge clk) sub_enable |-> alu_enable);

endmodule
